frame_writer: RTL and testbench

FRAME_WRITER -- requirements
Module: frame_writer

---
 rtl/frame_writer.sv | 130 +++++++++++++
 tb/tb_frame_writer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// Raster-order frame-buffer writer: accepts a pixel stream framed by pix_sof and
// issues one registered RAM write per pixel, with frame completion/abort pulses.
module frame_writer #(
  parameter int unsigned H_RES  = 320,
  parameter int unsigned V_RES  = 240,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_done,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic {StIdle, StWrite} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ram_address_d;
  logic [7:0]        ram_data_d;
  logic              ram_wren_d, frame_done_d, frame_err_d;
  logic              accept, last_px;

  assign pix_ready = init_done & reset;
  assign busy      = (state_q == StWrite);
  assign accept    = pix_valid & pix_ready;
  assign last_px   = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    ram_address_d = ram_address;
    ram_data_d    = ram_data;
    ram_wren_d    = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && pix_sof) begin
          state_d       = StWrite;
          ram_wren_d    = 1'b1;
          ram_address_d = '0;
          ram_data_d    = pix_data;
          x_d           = XW'(1);
          y_d           = '0;
          addr_d        = ADDR_W'(1);
        end
      end
      StWrite: begin
        if (!init_done) begin
          // RAM went away mid-frame: abandon silently.
          state_d = StIdle;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end else if (accept) begin
          ram_wren_d = 1'b1;
          ram_data_d = pix_data;
          if (pix_sof) begin
            // Early start-of-frame: restart the raster at the origin.
            frame_err_d   = 1'b1;
            ram_address_d = '0;
            x_d           = XW'(1);
            y_d           = '0;
            addr_d        = ADDR_W'(1);
          end else begin
            ram_address_d = addr_q;
            if (last_px) begin
              frame_done_d = 1'b1;
              state_d      = StIdle;
              x_d          = '0;
              y_d          = '0;
              addr_d       = '0;
            end else begin
              addr_d = addr_q + 1'b1;
              if (x_q == XW'(H_RES - 1)) begin
                x_d = '0;
                y_d = y_q + 1'b1;
              end else begin
                x_d = x_q + 1'b1;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      ram_address <= ram_address_d;
      ram_data    <= ram_data_d;
      ram_wren    <= ram_wren_d;
      frame_done  <= frame_done_d;
      frame_err   <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer on a reduced 64x48 frame: a pixel-index model checked every
// cycle, plus literal expectations at key points of each directed scenario.
module tb_frame_writer;

  localparam int unsigned H    = 64;
  localparam int unsigned V    = 48;
  localparam int unsigned AW   = 19;
  localparam int          NPIX = H * V;

  logic          clock, reset, init_done, pix_valid, pix_sof;
  logic [7:0]    pix_data;
  logic          pix_ready, ram_wren, busy, frame_done, frame_err;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data;

  frame_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .init_done   (init_done),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int wr_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a linear run of NPIX pixel indices; outputs follow one edge later.
  bit            m_in = 1'b0;
  int            m_pos = 0;
  logic          m_wren = 1'b0, m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = '0;

  always @(posedge clock) begin
    m_wren = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!reset) begin
      m_in   = 1'b0;
      m_pos  = 0;
      m_addr = '0;
      m_data = '0;
    end else if (!init_done) begin
      m_in = 1'b0;
    end else if (pix_valid) begin
      if (pix_sof) begin
        m_err  = m_in;
        m_in   = 1'b1;
        m_addr = '0;
        m_data = pix_data;
        m_wren = 1'b1;
        m_pos  = 1;
      end else if (m_in) begin
        m_addr = AW'(m_pos);
        m_data = pix_data;
        m_wren = 1'b1;
        if (m_pos == NPIX - 1) begin
          m_done = 1'b1;
          m_in   = 1'b0;
        end else begin
          m_pos++;
        end
      end
    end
    m_busy = m_in;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("ram_wren", ram_wren, m_wren);
      chk("ram_address", ram_address, m_addr);
      chk("ram_data", ram_data, m_data);
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, m_done);
      chk("frame_err", frame_err, m_err);
      chk("pix_ready", pix_ready, init_done & reset);
      if (ram_wren === 1'b1) wr_cnt++;
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  // Drive one cycle of stimulus; returns just after the edge's results are visible.
  task automatic cyc(input logic v, input logic [7:0] d, input logic s);
    pix_valid = v;
    pix_data  = d;
    pix_sof   = s;
    @(negedge clock);
    #1;
  endtask

  function automatic logic [7:0] pd(input int i);
    logic [31:0] t;
    t = i;
    return t[7:0] ^ 8'h5A;
  endfunction

  initial begin
    int i;
    int guard;
    reset     = 1'b0;
    init_done = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    chk_en = 1'b1;

    // Reset state, with a valid sof present to show reset dominates.
    cyc(1'b1, 8'hEE, 1'b1);
    chk("rst ram_wren", ram_wren, 0);
    chk("rst ram_address", ram_address, 0);
    chk("rst ram_data", ram_data, 0);
    chk("rst busy", busy, 0);
    chk("rst pix_ready", pix_ready, 0);

    // Pixels before any sof are dropped.
    reset = 1'b1;
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'h11 * k[7:0], 1'b0);
    chk("pre-sof wren", ram_wren, 0);
    chk("pre-sof busy", busy, 0);

    // Full continuous frame.
    wr_cnt = 0;
    done_cnt = 0;
    cyc(1'b1, 8'hA5, 1'b1);
    chk("sof wren", ram_wren, 1);
    chk("sof addr", ram_address, 0);
    chk("sof data", ram_data, 8'hA5);
    chk("sof busy", busy, 1);
    for (int k = 1; k < NPIX; k++) cyc(1'b1, pd(k), 1'b0);
    chk("last addr", ram_address, NPIX - 1);
    chk("last data", ram_data, pd(NPIX - 1));
    chk("last done", frame_done, 1);
    chk("last busy", busy, 0);
    chk("frame writes", wr_cnt, NPIX);
    chk("frame dones", done_cnt, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("post done", frame_done, 0);
    chk("post addr hold", ram_address, NPIX - 1);

    // Early sof after 1000 pixels.
    cyc(1'b1, pd(0), 1'b1);
    for (int k = 1; k < 1000; k++) cyc(1'b1, pd(k), 1'b0);
    chk("pre-err addr", ram_address, 999);
    cyc(1'b1, 8'h3C, 1'b1);
    chk("err pulse", frame_err, 1);
    chk("err addr", ram_address, 0);
    chk("err data", ram_data, 8'h3C);
    chk("err busy", busy, 1);
    for (int k = 1; k <= 3; k++) cyc(1'b1, pd(k), 1'b0);
    chk("after err addr", ram_address, 3);
    chk("after err pulse", frame_err, 0);

    // Full frame with random valid gaps; invalid cycles carry a junk sof.
    wr_cnt = 0;
    done_cnt = 0;
    cyc(1'b1, pd(0), 1'b1);
    i = 1;
    guard = 0;
    while (i < NPIX && guard < 20000) begin
      guard++;
      if ($urandom_range(0, 9) < 3) begin
        cyc(1'b0, 8'hFF, 1'b1);
      end else begin
        cyc(1'b1, pd(i), 1'b0);
        i++;
      end
    end
    chk("gap frame complete", i, NPIX);
    chk("gap frame writes", wr_cnt, NPIX);
    chk("gap frame dones", done_cnt, 1);
    chk("gap busy", busy, 0);

    // init_done drops at pixel 500.
    cyc(1'b1, pd(0), 1'b1);
    for (int k = 1; k < 500; k++) cyc(1'b1, pd(k), 1'b0);
    wr_cnt = 0;
    init_done = 1'b0;
    for (int k = 0; k < 10; k++) cyc(1'b1, pd(k), 1'b0);
    chk("init low writes", wr_cnt, 0);
    chk("init low busy", busy, 0);
    chk("init low ready", pix_ready, 0);
    init_done = 1'b1;
    cyc(1'b1, 8'h77, 1'b0);
    chk("init back no write", ram_wren, 0);
    chk("init back idle", busy, 0);
    cyc(1'b1, 8'h42, 1'b1);
    chk("restart addr", ram_address, 0);
    chk("restart data", ram_data, 8'h42);
    chk("restart wren", ram_wren, 1);

    // Reset mid-frame right after address 319.
    for (int k = 1; k < 320; k++) cyc(1'b1, pd(k), 1'b0);
    chk("pix319 addr", ram_address, 319);
    reset = 1'b0;
    cyc(1'b1, 8'h99, 1'b1);
    chk("midrst addr", ram_address, 0);
    chk("midrst data", ram_data, 0);
    chk("midrst wren", ram_wren, 0);
    chk("midrst busy", busy, 0);
    reset = 1'b1;
    cyc(1'b1, 8'hC3, 1'b1);
    chk("after rst addr", ram_address, 0);
    chk("after rst data", ram_data, 8'hC3);
    chk("after rst err", frame_err, 0);
    cyc(1'b0, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
